// File: rtl/csr_access_unit_if.sv
// Bus bundle between issue, the CSR access unit, the CSR register file and the write-back arbiter.
// master = the access unit side, slave = everything it talks to.
interface csr_access_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            ids_valid;
  logic            ids_ready;
  logic [2:0]      ids_funct3;
  logic [11:0]     ids_csr_addr;
  logic [XLEN-1:0] ids_rs1_data;
  logic [4:0]      ids_rs1_idx;
  logic [4:0]      ids_rd_idx;

  logic            csr_exs_en;
  logic            csr_rd;
  logic [11:0]     csr_rd_addr;
  logic [XLEN-1:0] csr_rd_data;
  logic            csr_illegal_rd;
  logic            csr_illegal_wr;
  logic            csr_wr;
  logic [1:0]      csr_wr_mode;
  logic [11:0]     csr_wr_addr;
  logic [XLEN-1:0] csr_wr_data;

  logic            excp_ilgl;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd_idx;
  logic [XLEN-1:0] wb_data;

  modport master (
    input  ids_valid, ids_funct3, ids_csr_addr, ids_rs1_data, ids_rs1_idx, ids_rd_idx,
    output ids_ready,
    output csr_exs_en, csr_rd, csr_rd_addr, csr_wr, csr_wr_mode, csr_wr_addr, csr_wr_data,
    input  csr_rd_data, csr_illegal_rd, csr_illegal_wr,
    output excp_ilgl,
    output wb_valid, wb_rd_idx, wb_data,
    input  wb_ready
  );

  modport slave (
    output ids_valid, ids_funct3, ids_csr_addr, ids_rs1_data, ids_rs1_idx, ids_rd_idx,
    input  ids_ready,
    input  csr_exs_en, csr_rd, csr_rd_addr, csr_wr, csr_wr_mode, csr_wr_addr, csr_wr_data,
    output csr_rd_data, csr_illegal_rd, csr_illegal_wr,
    input  excp_ilgl,
    input  wb_valid, wb_rd_idx, wb_data,
    output wb_ready
  );
endinterface

// File: rtl/csr_access_unit.sv
// Execute-stage CSRRW/CSRRS/CSRRC(/I) initiator: one op in flight, IDLE->EXEC->CAPT->RESP.
// Optional CSR_ACCESS_PRIV_CHECK_EN adds address-encoded privilege and read-only checks.
module csr_access_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          RD_X0_WB = 1'b0
) (
  input  logic                clk_i,
  input  logic                resetb_i,
  input  logic                clk_en_i,
  input  logic                flush_i,
  input  logic [1:0]          hpl_i,
  csr_access_unit_if.master   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;

  logic [2:0]      funct3_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [4:0]      rs1_idx_q;
  logic [4:0]      rd_idx_q;
  logic [XLEN-1:0] wb_data_q;

  logic            accept_c;
  logic            mode_rw_c;
  logic            do_rd_c;
  logic            do_wr_c;
  logic            wb_needed_c;
  logic            priv_ilgl_c;
  logic            illegal_c;

  logic            ids_ready_c;
  logic            exs_en_c;
  logic            rd_c;
  logic            wr_c;
  logic            excp_c;
  logic            wb_valid_c;

  assign accept_c    = bus.ids_valid & ~flush_i;

  // Decode works off the latched request so it stays stable for the whole EXEC cycle.
  assign mode_rw_c   = (funct3_q[1:0] == 2'b01);
  assign do_rd_c     = ~(mode_rw_c & (rd_idx_q == 5'd0));
  assign do_wr_c     = mode_rw_c | (rs1_idx_q != 5'd0);
  assign wb_needed_c = RD_X0_WB | (rd_idx_q != 5'd0);

`ifdef CSR_ACCESS_PRIV_CHECK_EN
  assign priv_ilgl_c = (hpl_i < addr_q[9:8]) | (do_wr_c & (addr_q[11:10] == 2'b11));
`else
  logic unused_hpl;
  assign unused_hpl  = ^hpl_i;
  assign priv_ilgl_c = 1'b0;
`endif

  assign illegal_c = (funct3_q[1:0] == 2'b00)
                   | (do_rd_c & bus.csr_illegal_rd)
                   | (do_wr_c & bus.csr_illegal_wr)
                   | priv_ilgl_c;

  // State register; a low clock enable freezes the FSM.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= ST_IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  // Next state and control strobes.
  always_comb begin
    state_d     = state_q;
    ids_ready_c = 1'b0;
    exs_en_c    = 1'b0;
    rd_c        = 1'b0;
    wr_c        = 1'b0;
    excp_c      = 1'b0;
    wb_valid_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ids_ready_c = 1'b1;
        if (accept_c) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (!flush_i) begin
          exs_en_c = 1'b1;
          rd_c     = do_rd_c & ~illegal_c;
          wr_c     = do_wr_c & ~illegal_c;
          excp_c   = illegal_c;
          if (!illegal_c && wb_needed_c) state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        wb_valid_c = 1'b1;
        if (bus.wb_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture on accept and old-value capture in CAPT.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      funct3_q   <= 3'd0;
      addr_q     <= 12'd0;
      rs1_data_q <= '0;
      rs1_idx_q  <= 5'd0;
      rd_idx_q   <= 5'd0;
      wb_data_q  <= '0;
    end else if (clk_en_i) begin
      if (state_q == ST_IDLE && accept_c) begin
        funct3_q   <= bus.ids_funct3;
        addr_q     <= bus.ids_csr_addr;
        rs1_data_q <= bus.ids_rs1_data;
        rs1_idx_q  <= bus.ids_rs1_idx;
        rd_idx_q   <= bus.ids_rd_idx;
      end
      if (state_q == ST_CAPT) begin
        wb_data_q <= do_rd_c ? bus.csr_rd_data : '0;
      end
    end
  end

  // Handshake and strobe outputs drop while the clock enable is low; buses stay driven.
  assign bus.ids_ready   = ids_ready_c & clk_en_i;
  assign bus.csr_exs_en  = exs_en_c & clk_en_i;
  assign bus.csr_rd      = rd_c & clk_en_i;
  assign bus.csr_wr      = wr_c & clk_en_i;
  assign bus.excp_ilgl   = excp_c & clk_en_i;
  assign bus.wb_valid    = wb_valid_c & clk_en_i;
  assign bus.csr_wr_mode = clk_en_i ? funct3_q[1:0] : 2'b00;

  assign bus.csr_rd_addr = addr_q;
  assign bus.csr_wr_addr = addr_q;
  assign bus.csr_wr_data = funct3_q[2] ? XLEN'(rs1_idx_q) : rs1_data_q;
  assign bus.wb_rd_idx   = rd_idx_q;
  assign bus.wb_data     = wb_data_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed self-checking bench for csr_access_unit with a small registered-read CSR file model.
module tb_csr_access_unit;

  logic       clk_i;
  logic       resetb_i;
  logic       clk_en_i;
  logic       flush_i;
  logic [1:0] hpl_i;
  int         checks;
  int         errors;
  int         wr_count;
  int         wr_snap;

  csr_access_unit_if #(.XLEN(32)) bus();

  csr_access_unit #(.XLEN(32), .RD_X0_WB(1'b0)) dut (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .clk_en_i (clk_en_i),
    .flush_i  (flush_i),
    .hpl_i    (hpl_i),
    .bus      (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] csr_val(input logic [11:0] a);
    case (a)
      12'h340: csr_val = 32'h0000_0001;
      12'h305: csr_val = 32'h8000_0100;
      12'h300: csr_val = 32'h0000_1888;
      default: csr_val = 32'hBAD0_0000;
    endcase
  endfunction

  // CSR file: read data registered one cycle after exs_en & rd; count committed writes.
  always @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      bus.csr_rd_data <= 32'h0;
    end else if (bus.csr_exs_en && bus.csr_rd) begin
      bus.csr_rd_data <= csr_val(bus.csr_rd_addr);
    end
  end

  always @(posedge clk_i) begin
    if (bus.csr_wr) wr_count <= wr_count + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d,
                       input logic [4:0] rs1, input logic [4:0] rd);
    bus.ids_funct3   = f3;
    bus.ids_csr_addr = a;
    bus.ids_rs1_data = d;
    bus.ids_rs1_idx  = rs1;
    bus.ids_rd_idx   = rd;
    bus.ids_valid    = 1'b1;
    tick();
    bus.ids_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetb_i = 1'b0;
    #1;
    checks++; if (bus.ids_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", bus.ids_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b exp 0", bus.wb_valid); end
    checks++; if (bus.csr_wr !== 1'b0 || bus.csr_exs_en !== 1'b0) begin errors++; $display("FAIL rst_strobes: got wr=%b en=%b exp 0", bus.csr_wr, bus.csr_exs_en); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data: got %h exp 0", bus.wb_data); end
    checks++; if (bus.csr_rd_addr !== 12'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", bus.csr_rd_addr); end
    tick(); tick();
    resetb_i = 1'b1;
    tick();
  endtask

  task automatic test_csrrw();
    issue(3'b001, 12'h340, 32'hDEADBEEF, 5'd6, 5'd5);
    checks++; if (bus.csr_exs_en !== 1'b1) begin errors++; $display("FAIL rw_exs_en: got %b exp 1", bus.csr_exs_en); end
    checks++; if (bus.csr_wr !== 1'b1) begin errors++; $display("FAIL rw_wr: got %b exp 1", bus.csr_wr); end
    checks++; if (bus.csr_rd !== 1'b1) begin errors++; $display("FAIL rw_rd: got %b exp 1", bus.csr_rd); end
    checks++; if (bus.csr_wr_mode !== 2'b01) begin errors++; $display("FAIL rw_mode: got %b exp 01", bus.csr_wr_mode); end
    checks++; if (bus.csr_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rw_data: got %h exp deadbeef", bus.csr_wr_data); end
    checks++; if (bus.csr_wr_addr !== 12'h340) begin errors++; $display("FAIL rw_addr: got %h exp 340", bus.csr_wr_addr); end
    checks++; if (bus.ids_ready !== 1'b0) begin errors++; $display("FAIL rw_busy: got %b exp 0", bus.ids_ready); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rw_capt_valid: got %b exp 0", bus.wb_valid); end
    tick();
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL rw_wb_valid: got %b exp 1", bus.wb_valid); end
    checks++; if (bus.wb_rd_idx !== 5'd5) begin errors++; $display("FAIL rw_wb_idx: got %0d exp 5", bus.wb_rd_idx); end
    checks++; if (bus.wb_data !== 32'h1) begin errors++; $display("FAIL rw_wb_data: got %h exp 1", bus.wb_data); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.ids_ready !== 1'b1) begin errors++; $display("FAIL rw_done: got valid=%b ready=%b exp 0/1", bus.wb_valid, bus.ids_ready); end
  endtask

  task automatic test_csrrs_x0();
    issue(3'b010, 12'h305, 32'h0, 5'd0, 5'd7);
    checks++; if (bus.csr_wr !== 1'b0) begin errors++; $display("FAIL rs_wr: got %b exp 0", bus.csr_wr); end
    checks++; if (bus.csr_rd !== 1'b1) begin errors++; $display("FAIL rs_rd: got %b exp 1", bus.csr_rd); end
    checks++; if (bus.csr_wr_mode !== 2'b10) begin errors++; $display("FAIL rs_mode: got %b exp 10", bus.csr_wr_mode); end
    tick(); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_rd_idx !== 5'd7) begin errors++; $display("FAIL rs_wb: got valid=%b idx=%0d exp 1/7", bus.wb_valid, bus.wb_rd_idx); end
    checks++; if (bus.wb_data !== 32'h8000_0100) begin errors++; $display("FAIL rs_wb_data: got %h exp 80000100", bus.wb_data); end
    tick();
  endtask

  task automatic test_csrrci_backpressure();
    bus.wb_ready = 1'b0;
    issue(3'b111, 12'h300, 32'hFFFF_FFFF, 5'd8, 5'd3);
    checks++; if (bus.csr_wr_mode !== 2'b11) begin errors++; $display("FAIL rci_mode: got %b exp 11", bus.csr_wr_mode); end
    checks++; if (bus.csr_wr_data !== 32'h8) begin errors++; $display("FAIL rci_data: got %h exp 8", bus.csr_wr_data); end
    checks++; if (bus.csr_wr !== 1'b1) begin errors++; $display("FAIL rci_wr: got %b exp 1", bus.csr_wr); end
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      flush_i = (i == 2);
      #1;
      checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1888) begin errors++; $display("FAIL rci_hold%0d: got valid=%b data=%h exp 1/1888", i, bus.wb_valid, bus.wb_data); end
      checks++; if (bus.wb_rd_idx !== 5'd3 || bus.ids_ready !== 1'b0) begin errors++; $display("FAIL rci_hold_idx%0d: got idx=%0d ready=%b exp 3/0", i, bus.wb_rd_idx, bus.ids_ready); end
      tick();
    end
    flush_i = 1'b0;
    bus.wb_ready = 1'b1;
    #1;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL rci_last: got %b exp 1", bus.wb_valid); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.ids_ready !== 1'b1) begin errors++; $display("FAIL rci_done: got valid=%b ready=%b exp 0/1", bus.wb_valid, bus.ids_ready); end
  endtask

  task automatic test_illegal();
    wr_snap = wr_count;
    issue(3'b100, 12'h340, 32'h1234, 5'd1, 5'd5);
    checks++; if (bus.excp_ilgl !== 1'b1) begin errors++; $display("FAIL ilf3_excp: got %b exp 1", bus.excp_ilgl); end
    checks++; if (bus.csr_wr !== 1'b0 || bus.csr_rd !== 1'b0) begin errors++; $display("FAIL ilf3_strobes: got wr=%b rd=%b exp 0/0", bus.csr_wr, bus.csr_rd); end
    tick();
    checks++; if (bus.excp_ilgl !== 1'b0 || bus.ids_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL ilf3_after: got excp=%b ready=%b valid=%b exp 0/1/0", bus.excp_ilgl, bus.ids_ready, bus.wb_valid); end
    bus.csr_illegal_wr = 1'b1;
    issue(3'b001, 12'h340, 32'h1234, 5'd1, 5'd5);
    checks++; if (bus.excp_ilgl !== 1'b1 || bus.csr_wr !== 1'b0) begin errors++; $display("FAIL ilwr_excp: got excp=%b wr=%b exp 1/0", bus.excp_ilgl, bus.csr_wr); end
    tick();
    bus.csr_illegal_wr = 1'b0;
    tick(); tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.ids_ready !== 1'b1) begin errors++; $display("FAIL ilwr_nowb: got valid=%b ready=%b exp 0/1", bus.wb_valid, bus.ids_ready); end
    checks++; if (wr_count !== wr_snap) begin errors++; $display("FAIL il_writes: got %0d exp %0d", wr_count, wr_snap); end
  endtask

  task automatic test_flush();
    wr_snap = wr_count;
    issue(3'b001, 12'h340, 32'hCAFE, 5'd2, 5'd9);
    flush_i = 1'b1;
    #1;
    checks++; if (bus.csr_exs_en !== 1'b0 || bus.csr_wr !== 1'b0) begin errors++; $display("FAIL fl_exec: got en=%b wr=%b exp 0/0", bus.csr_exs_en, bus.csr_wr); end
    tick();
    flush_i = 1'b0;
    #1;
    checks++; if (bus.ids_ready !== 1'b1 || wr_count !== wr_snap) begin errors++; $display("FAIL fl_idle: got ready=%b writes=%0d exp 1/%0d", bus.ids_ready, wr_count, wr_snap); end
    tick(); tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL fl_nowb: got %b exp 0", bus.wb_valid); end
    // flush while a request is offered in IDLE: not taken
    flush_i = 1'b1;
    issue(3'b001, 12'h340, 32'hCAFE, 5'd2, 5'd9);
    checks++; if (bus.ids_ready !== 1'b1 || bus.csr_exs_en !== 1'b0) begin errors++; $display("FAIL fl_idle_req: got ready=%b en=%b exp 1/0", bus.ids_ready, bus.csr_exs_en); end
    flush_i = 1'b0;
    issue(3'b001, 12'h340, 32'hCAFE, 5'd2, 5'd9);
    checks++; if (bus.csr_wr !== 1'b1) begin errors++; $display("FAIL fl_next_wr: got %b exp 1", bus.csr_wr); end
    tick(); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1 || bus.wb_rd_idx !== 5'd9) begin errors++; $display("FAIL fl_next_wb: got valid=%b data=%h idx=%0d exp 1/1/9", bus.wb_valid, bus.wb_data, bus.wb_rd_idx); end
    tick();
  endtask

  task automatic test_rd_x0();
    issue(3'b001, 12'h340, 32'h55, 5'd4, 5'd0);
    checks++; if (bus.csr_rd !== 1'b0 || bus.csr_wr !== 1'b1) begin errors++; $display("FAIL x0_exec: got rd=%b wr=%b exp 0/1", bus.csr_rd, bus.csr_wr); end
    tick();
    checks++; if (bus.ids_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL x0_nowb: got ready=%b valid=%b exp 1/0", bus.ids_ready, bus.wb_valid); end
  endtask

  task automatic test_clk_en();
    issue(3'b001, 12'h340, 32'h77, 5'd4, 5'd4);
    clk_en_i = 1'b0;
    #1;
    checks++; if (bus.csr_exs_en !== 1'b0 || bus.csr_wr !== 1'b0 || bus.csr_rd !== 1'b0) begin errors++; $display("FAIL ce_strobes: got en=%b wr=%b rd=%b exp 0", bus.csr_exs_en, bus.csr_wr, bus.csr_rd); end
    checks++; if (bus.csr_wr_addr !== 12'h340 || bus.csr_wr_data !== 32'h77) begin errors++; $display("FAIL ce_bus: got addr=%h data=%h exp 340/77", bus.csr_wr_addr, bus.csr_wr_data); end
    tick(); tick();
    checks++; if (bus.wb_valid !== 1'b0 || bus.ids_ready !== 1'b0) begin errors++; $display("FAIL ce_frozen: got valid=%b ready=%b exp 0/0", bus.wb_valid, bus.ids_ready); end
    clk_en_i = 1'b1;
    #1;
    checks++; if (bus.csr_wr !== 1'b1) begin errors++; $display("FAIL ce_resume: got %b exp 1", bus.csr_wr); end
    tick(); tick();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h1) begin errors++; $display("FAIL ce_wb: got valid=%b data=%h exp 1/1", bus.wb_valid, bus.wb_data); end
    tick();
  endtask

  task automatic test_priv();
    hpl_i = 2'b00;
    issue(3'b001, 12'h300, 32'h9, 5'd1, 5'd0);
`ifdef CSR_ACCESS_PRIV_CHECK_EN
    checks++; if (bus.excp_ilgl !== 1'b1 || bus.csr_wr !== 1'b0) begin errors++; $display("FAIL priv: got excp=%b wr=%b exp 1/0", bus.excp_ilgl, bus.csr_wr); end
`else
    checks++; if (bus.excp_ilgl !== 1'b0 || bus.csr_wr !== 1'b1) begin errors++; $display("FAIL priv: got excp=%b wr=%b exp 0/1", bus.excp_ilgl, bus.csr_wr); end
`endif
    tick();
    hpl_i = 2'b11;
  endtask

  task automatic test_reset_mid_op();
    wr_snap = wr_count;
    issue(3'b001, 12'h340, 32'hAA, 5'd1, 5'd6);
    resetb_i = 1'b0;
    #1;
    checks++; if (bus.csr_wr !== 1'b0 || bus.ids_ready !== 1'b1) begin errors++; $display("FAIL rmid_reset: got wr=%b ready=%b exp 0/1", bus.csr_wr, bus.ids_ready); end
    tick(); tick();
    resetb_i = 1'b1;
    tick(); tick(); tick();
    checks++; if (wr_count !== wr_snap || bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_discard: got writes=%0d valid=%b exp %0d/0", wr_count, bus.wb_valid, wr_snap); end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    wr_count           = 0;
    wr_snap            = 0;
    clk_en_i           = 1'b1;
    flush_i            = 1'b0;
    hpl_i              = 2'b11;
    bus.ids_valid      = 1'b0;
    bus.ids_funct3     = 3'd0;
    bus.ids_csr_addr   = 12'd0;
    bus.ids_rs1_data   = 32'd0;
    bus.ids_rs1_idx    = 5'd0;
    bus.ids_rd_idx     = 5'd0;
    bus.csr_illegal_rd = 1'b0;
    bus.csr_illegal_wr = 1'b0;
    bus.wb_ready       = 1'b1;
    test_reset();
    test_csrrw();
    test_csrrs_x0();
    test_csrrci_backpressure();
    test_illegal();
    test_flush();
    test_rd_x0();
    test_clk_en();
    test_priv();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
